// File: rtl/activation_ctrl_if.sv
// activation_ctrl_if: command, matmul row stream, activation-unit link and
// output FIFO port of activation_ctrl, bundled into one interface.
// slave = controller view, master = surrounding system / bench view.
`ifndef MAT_MUL_SIZE
`define MAT_MUL_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH `MAT_MUL_SIZE
`endif

interface activation_ctrl_if #(
  parameter int ROW_CNT_WIDTH = 8
);
  localparam int DATA_W = `MAT_MUL_SIZE * `DWIDTH;

  // command
  logic                     start;
  logic [ROW_CNT_WIDTH-1:0] num_rows;
  logic                     enable_activation;
  logic [`MASK_WIDTH-1:0]   validity_mask;
  // matmul row stream
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  // activation unit link
  logic                     act_enable;
  logic                     act_in_valid;
  logic [DATA_W-1:0]        act_in_data;
  logic [`MASK_WIDTH-1:0]   act_mask;
  logic                     act_out_valid;
  logic [DATA_W-1:0]        act_out_data;
  // output FIFO head
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready;
  // status
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, num_rows, enable_activation, validity_mask,
    input  in_valid, in_data, act_out_valid, act_out_data, out_ready,
    output in_ready, act_enable, act_in_valid, act_in_data, act_mask,
    output out_valid, out_data, busy, done
  );

  modport master (
    output start, num_rows, enable_activation, validity_mask,
    output in_valid, in_data, act_out_valid, act_out_data, out_ready,
    input  in_ready, act_enable, act_in_valid, act_in_data, act_mask,
    input  out_valid, out_data, busy, done
  );
endinterface

// File: rtl/activation_ctrl.sv
// activation_ctrl: sequences matmul result rows through the (non-stallable)
// activation unit into a small output FIFO. Rows are issued only while
// in-flight rows plus FIFO occupancy leave a free FIFO slot, so nothing the
// activation unit produces can be dropped.
// Optional feature macro: ACTIVATION_CTRL_LANE_MASK_EN -- when defined, lanes
// whose latched validity_mask bit is 0 are zeroed as rows enter the FIFO.
`ifndef MAT_MUL_SIZE
`define MAT_MUL_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH `MAT_MUL_SIZE
`endif

module activation_ctrl #(
  parameter int FIFO_DEPTH    = 4,
  parameter int ROW_CNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  activation_ctrl_if.slave  bus
);
  localparam int LANES  = `MAT_MUL_SIZE;
  localparam int DW     = `DWIDTH;
  localparam int DATA_W = LANES * DW;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [ROW_CNT_WIDTH-1:0] rows_reg;
  logic [ROW_CNT_WIDTH-1:0] issued_reg;
  logic                     enable_reg;
  logic [`MASK_WIDTH-1:0]   mask_reg;
  logic [CNT_W-1:0]         inflight_reg, inflight_next;
  logic [CNT_W-1:0]         fifo_count_reg, fifo_count_next;
  logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic                     act_valid_reg;
  logic [DATA_W-1:0]        act_data_reg;
  logic [DATA_W-1:0]        fifo_mem [FIFO_DEPTH];

  logic                     start_take;
  logic                     in_ready_comb;
  logic                     accept;
  logic                     capture;
  logic                     pop;
  logic                     last_issue;
  logic [CNT_W:0]           credit_sum;
  logic [DATA_W-1:0]        lane_keep;
  logic [DATA_W-1:0]        fifo_wdata;
  logic                     busy_comb;
  logic                     done_comb;

  // Handshake qualifiers; issue credit uses registered counts only
  assign start_take    = (state_reg == IDLE) && bus.start;
  assign credit_sum    = {1'b0, inflight_reg} + {1'b0, fifo_count_reg};
  assign in_ready_comb = (state_reg == RUN) && (issued_reg < rows_reg) &&
                         (credit_sum < DEPTH_V);
  assign accept        = bus.in_valid && in_ready_comb;
  assign capture       = bus.act_out_valid;
  assign pop           = (fifo_count_reg != '0) && bus.out_ready;
  assign last_issue    = ((issued_reg + ROW_CNT_WIDTH'(1)) == rows_reg);

  // Per-lane write mask for FIFO entries
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef ACTIVATION_CTRL_LANE_MASK_EN
      assign lane_keep[gi*DW +: DW] = {DW{mask_reg[gi]}};
`else
      assign lane_keep[gi*DW +: DW] = {DW{1'b1}};
`endif
    end
  endgenerate
  assign fifo_wdata = bus.act_out_data & lane_keep;

  // Next values of the in-flight and FIFO occupancy counters
  always_comb begin
    inflight_next   = inflight_reg;
    fifo_count_next = fifo_count_reg;
    case ({accept, capture})
      2'b10:   inflight_next = inflight_reg + CNT_W'(1);
      2'b01:   inflight_next = inflight_reg - CNT_W'(1);
      default: inflight_next = inflight_reg;
    endcase
    case ({capture, pop})
      2'b10:   fifo_count_next = fifo_count_reg + CNT_W'(1);
      2'b01:   fifo_count_next = fifo_count_reg - CNT_W'(1);
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  // Pass sequencing: next state plus busy/done decode
  always_comb begin
    state_next = state_reg;
    busy_comb  = 1'b0;
    done_comb  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = (bus.num_rows == '0) ? DONE : RUN;
      end
      RUN: begin
        busy_comb = 1'b1;
        if (accept && last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        busy_comb = 1'b1;
        // look ahead so done follows the final pop by one cycle
        if ((inflight_next == '0) && (fifo_count_next == '0)) state_next = DONE;
      end
      DONE: begin
        done_comb  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Pass configuration, latched on an accepted start and held for the pass
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_reg   <= '0;
      enable_reg <= 1'b0;
      mask_reg   <= '0;
    end else if (start_take) begin
      rows_reg   <= bus.num_rows;
      enable_reg <= bus.enable_activation;
      mask_reg   <= bus.validity_mask;
    end
  end

  // Issued and in-flight row counters
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_reg   <= '0;
      inflight_reg <= '0;
    end else if (start_take) begin
      issued_reg   <= '0;
      inflight_reg <= '0;
    end else begin
      if (accept) issued_reg <= issued_reg + ROW_CNT_WIDTH'(1);
      inflight_reg <= inflight_next;
    end
  end

  // Register accepted rows toward the activation unit
  always_ff @(posedge clk) begin
    if (reset) begin
      act_valid_reg <= 1'b0;
      act_data_reg  <= '0;
    end else begin
      act_valid_reg <= accept;
      if (accept) act_data_reg <= bus.in_data;
    end
  end

  // Output FIFO pointers and occupancy; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (capture) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      fifo_count_reg <= fifo_count_next;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (capture) fifo_mem[wr_ptr_reg] <= fifo_wdata;
  end

  assign bus.in_ready     = in_ready_comb;
  assign bus.act_enable   = enable_reg;
  assign bus.act_mask     = mask_reg;
  assign bus.act_in_valid = act_valid_reg;
  assign bus.act_in_data  = act_data_reg;
  assign bus.out_valid    = (fifo_count_reg != '0);
  assign bus.out_data     = (fifo_count_reg != '0) ? fifo_mem[rd_ptr_reg] : '0;
  assign bus.busy         = busy_comb;
  assign bus.done         = done_comb;
endmodule

// File: tb/tb_activation_ctrl.sv
// tb_activation_ctrl: randomized self-checking bench for activation_ctrl.
// Contains a stand-in activation unit (registered ReLU, combinational bypass)
// and a scoreboard whose expected rows come from the pass rules directly.
// Honours ACTIVATION_CTRL_LANE_MASK_EN when choosing expected FIFO data.
`ifndef MAT_MUL_SIZE
`define MAT_MUL_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH `MAT_MUL_SIZE
`endif

module tb_activation_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int RCW        = 8;
  localparam int LANES      = `MAT_MUL_SIZE;
  localparam int DW         = `DWIDTH;
  localparam int W          = LANES * DW;
  localparam int MW         = `MASK_WIDTH;
`ifdef ACTIVATION_CTRL_LANE_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  activation_ctrl_if #(.ROW_CNT_WIDTH(RCW)) bus ();

  activation_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .ROW_CNT_WIDTH(RCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- stand-in activation unit ----------------
  function automatic logic [W-1:0] relu(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < LANES; i++)
      if (d[i*DW + DW - 1]) r[i*DW +: DW] = '0;
    return r;
  endfunction

  logic         stub_v;
  logic [W-1:0] stub_d;
  always @(posedge clk) begin
    if (reset) begin
      stub_v <= 1'b0;
      stub_d <= '0;
    end else begin
      stub_v <= bus.act_in_valid;
      stub_d <= relu(bus.act_in_data);
    end
  end
  assign bus.act_out_valid = bus.act_enable ? stub_v : bus.act_in_valid;
  assign bus.act_out_data  = bus.act_enable ? stub_d : bus.act_in_data;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] exp_row(input logic [W-1:0] d, input logic en,
                                           input logic [MW-1:0] m);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < LANES; i++) begin
      if (en && ($signed(d[i*DW +: DW]) < 0)) r[i*DW +: DW] = '0;
      if (MASK_EN && !m[i]) r[i*DW +: DW] = '0;
    end
    return r;
  endfunction

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cnt, cap_cnt, pop_cnt, done_cnt, occ, max_occ;
  int first_acc, last_acc, first_ov, last_pop, done_cyc;
  bit busy_seen, busy_at_done;
  int valid_mode = 0;   // 0: in_valid whenever rows remain, 1: random
  int ready_mode = 0;   // 0: low, 1: high, 2: random
  logic          cur_en;
  logic [MW-1:0] cur_mask;
  logic [W-1:0]  src_q[$];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];

  task automatic clear_board();
    acc_cnt = 0; cap_cnt = 0; pop_cnt = 0; done_cnt = 0; occ = 0; max_occ = 0;
    first_acc = -1; last_acc = -1; first_ov = -1; last_pop = -1; done_cyc = -1;
    busy_seen = 0; busy_at_done = 0;
    exp_q.delete(); got_q.delete();
  endtask

  // One clock: observe handshakes in the current cycle, advance, drive inputs
  task automatic tick();
    logic [W-1:0] tmp;
    if (!reset) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(exp_row(bus.in_data, cur_en, cur_mask));
        if (src_q.size() != 0) tmp = src_q.pop_front();
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        pop_cnt++;
        last_pop = cyc;
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.act_out_valid) cap_cnt++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.done && bus.busy) busy_at_done = 1;
      if (bus.busy) busy_seen = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    occ = cap_cnt - pop_cnt;
    if (occ > max_occ) max_occ = occ;
    if (src_q.size() != 0) begin
      bus.in_data  = src_q[0];
      bus.in_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end else begin
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
    end
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic start_pass(input int rows, input logic en, input logic [MW-1:0] mask);
    clear_board();
    cur_en   = en;
    cur_mask = mask;
    bus.start = 1'b1;
    bus.num_rows = RCW'(rows);
    bus.enable_activation = en;
    bus.validity_mask = mask;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    timed_out = (done_cnt == 0);
    repeat (3) tick();
  endtask

  function automatic logic [W-1:0] mk_row(input logic [DW-1:0] lane0);
    logic [63:0] t;
    logic [W-1:0] r;
    t = {$urandom, $urandom};
    r = t[W-1:0];
    r[DW-1:0] = lane0;
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 0; bus.num_rows = '0; bus.enable_activation = 0; bus.validity_mask = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    valid_mode = 0; ready_mode = 0;
    clear_board();
    reset = 1'b1;
    repeat (3) tick();
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    vectors++; if (bus.act_enable !== 1'b0) begin miscompares++; $display("FAIL reset_act_enable got=%b exp=0", bus.act_enable); end
    vectors++; if (bus.act_in_valid !== 1'b0) begin miscompares++; $display("FAIL reset_act_in_valid got=%b exp=0", bus.act_in_valid); end
    vectors++; if (bus.act_in_data !== '0) begin miscompares++; $display("FAIL reset_act_in_data got=%h exp=0", bus.act_in_data); end
    vectors++; if (bus.act_mask !== '0) begin miscompares++; $display("FAIL reset_act_mask got=%h exp=0", bus.act_mask); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    reset = 1'b0;
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_in_ready got=%b exp=0", bus.in_ready); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_basic();
    logic [DW-1:0] in_l0  [3] = '{8'h85, 8'h05, 8'h7F};
    logic [DW-1:0] out_l0 [3] = '{8'h00, 8'h05, 8'h7F};
    bit to;
    valid_mode = 0; ready_mode = 1; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) src_q.push_back(mk_row(in_l0[i]));
    start_pass(3, 1'b1, '1);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_after_start got=%b exp=1", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready_after_start got=%b exp=1", bus.in_ready); end
    wait_done(60, to);
    vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout got=no_done exp=done"); end
    vectors++; if (got_q.size() != 3) begin miscompares++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      $display("basic row %0d: out=%h lane0=%h", i, got_q[i], got_q[i][DW-1:0]);
      vectors++; if (got_q[i][DW-1:0] !== out_l0[i]) begin miscompares++; $display("FAIL basic_lane0[%0d] got=%h exp=%h", i, got_q[i][DW-1:0], out_l0[i]); end
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_row[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (first_ov - first_acc != 3) begin miscompares++; $display("FAIL basic_latency got=%0d exp=3", first_ov - first_acc); end
    vectors++; if (last_acc - first_acc != 2) begin miscompares++; $display("FAIL basic_throughput got=%0d exp=2", last_acc - first_acc); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    vectors++; if (busy_at_done) begin miscompares++; $display("FAIL basic_busy_with_done got=1 exp=0"); end
  endtask

  task automatic test_bypass();
    bit to;
    valid_mode = 0; ready_mode = 1; bus.out_ready = 1'b1;
    src_q.push_back(mk_row(8'h85));
    start_pass(1, 1'b0, '1);
    wait_done(40, to);
    vectors++; if (to) begin miscompares++; $display("FAIL bypass_timeout got=no_done exp=done"); end
    vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL bypass_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() != 0) begin
      $display("bypass row: out=%h", got_q[0]);
      vectors++; if (got_q[0][DW-1:0] !== 8'h85) begin miscompares++; $display("FAIL bypass_lane0 got=%h exp=85", got_q[0][DW-1:0]); end
      vectors++; if (got_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL bypass_row got=%h exp=%h", got_q[0], exp_q[0]); end
    end
    vectors++; if (first_ov - first_acc != 2) begin miscompares++; $display("FAIL bypass_latency got=%0d exp=2", first_ov - first_acc); end
  endtask

  task automatic test_backpressure();
    bit to;
    valid_mode = 0; ready_mode = 0; bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(mk_row(DW'($urandom)));
    start_pass(6, 1'b1, '1);
    repeat (20) tick();
    $display("backpressure: accepted %0d while stalled", acc_cnt);
    vectors++; if (acc_cnt != FIFO_DEPTH) begin miscompares++; $display("FAIL bp_stalled_accepts got=%0d exp=%0d", acc_cnt, FIFO_DEPTH); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    ready_mode = 1; bus.out_ready = 1'b1;
    wait_done(80, to);
    vectors++; if (to) begin miscompares++; $display("FAIL bp_timeout got=no_done exp=done"); end
    vectors++; if (acc_cnt != 6) begin miscompares++; $display("FAIL bp_accepts got=%0d exp=6", acc_cnt); end
    vectors++; if (got_q.size() != 6) begin miscompares++; $display("FAIL bp_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_row[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
    vectors++; if (done_cyc - last_pop != 1) begin miscompares++; $display("FAIL bp_done_timing got=%0d exp=1", done_cyc - last_pop); end
    vectors++; if (max_occ > FIFO_DEPTH) begin miscompares++; $display("FAIL bp_overflow got=%0d exp<=%0d", max_occ, FIFO_DEPTH); end
  endtask

  task automatic test_zero_rows();
    valid_mode = 0; ready_mode = 1;
    start_pass(0, 1'b1, '1);
    $display("zero rows: done=%b busy=%b in_ready=%b", bus.done, bus.busy, bus.in_ready);
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL zero_done got=%b exp=1", bus.done); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL zero_done_width got=%b exp=0", bus.done); end
    repeat (4) tick();
    vectors++; if (busy_seen) begin miscompares++; $display("FAIL zero_busy_seen got=1 exp=0"); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_mask();
    bit to;
    logic [W-1:0] want;
    want = MASK_EN ? {LANES/2{16'h0011}} : {LANES{8'h11}};
    valid_mode = 0; ready_mode = 1; bus.out_ready = 1'b1;
    src_q.push_back({LANES{8'h11}});
    start_pass(1, 1'b1, MW'(4'b0101));
    vectors++; if (bus.act_mask !== MW'(4'b0101)) begin miscompares++; $display("FAIL mask_act_mask got=%b exp=0101", bus.act_mask); end
    wait_done(40, to);
    vectors++; if (to) begin miscompares++; $display("FAIL mask_timeout got=no_done exp=done"); end
    vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL mask_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() != 0) begin
      $display("mask row: out=%h", got_q[0]);
      vectors++; if (got_q[0] !== want) begin miscompares++; $display("FAIL mask_row got=%h exp=%h", got_q[0], want); end
    end
  endtask

  task automatic test_reset_mid_pass();
    bit to;
    int n;
    valid_mode = 0; ready_mode = 0; bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(mk_row(DW'($urandom)));
    start_pass(5, 1'b1, MW'(4'b1010));
    n = 0;
    while (acc_cnt < 2 && n < 30) begin tick(); n++; end
    vectors++; if (acc_cnt != 2) begin miscompares++; $display("FAIL midrst_accepts got=%0d exp=2", acc_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    src_q.delete();
    bus.in_valid = 1'b0;
    $display("mid-pass reset: busy=%b out_valid=%b act_in_valid=%b", bus.busy, bus.out_valid, bus.act_in_valid);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL midrst_out_data got=%h exp=0", bus.out_data); end
    vectors++; if (bus.act_in_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_act_in_valid got=%b exp=0", bus.act_in_valid); end
    vectors++; if (bus.act_in_data !== '0) begin miscompares++; $display("FAIL midrst_act_in_data got=%h exp=0", bus.act_in_data); end
    vectors++; if (bus.act_mask !== '0) begin miscompares++; $display("FAIL midrst_act_mask got=%b exp=0", bus.act_mask); end
    vectors++; if (bus.act_enable !== 1'b0) begin miscompares++; $display("FAIL midrst_act_enable got=%b exp=0", bus.act_enable); end
    repeat (5) tick();
    vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL midrst_spurious_done got=%0d exp=0", done_cnt); end
    ready_mode = 1; bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) src_q.push_back(mk_row(DW'($urandom)));
    start_pass(2, 1'b0, '1);
    wait_done(40, to);
    vectors++; if (to) begin miscompares++; $display("FAIL midrst_new_timeout got=no_done exp=done"); end
    vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL midrst_new_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL midrst_new_row[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL midrst_new_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    bit to;
    valid_mode = 0; ready_mode = 1; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back(mk_row(DW'($urandom)));
    start_pass(8, 1'b1, '1);
    tick();
    // a start during the pass must be ignored, config stays latched
    bus.start = 1'b1; bus.num_rows = RCW'(1); bus.enable_activation = 1'b0; bus.validity_mask = '0;
    tick();
    bus.start = 1'b0;
    vectors++; if (bus.act_enable !== 1'b1) begin miscompares++; $display("FAIL b2b_act_enable_held got=%b exp=1", bus.act_enable); end
    wait_done(80, to);
    vectors++; if (to) begin miscompares++; $display("FAIL b2b_timeout got=no_done exp=done"); end
    vectors++; if (acc_cnt != 8) begin miscompares++; $display("FAIL b2b_accepts got=%0d exp=8", acc_cnt); end
    vectors++; if (last_acc - first_acc != 7) begin miscompares++; $display("FAIL b2b_throughput got=%0d exp=7", last_acc - first_acc); end
    vectors++; if (got_q.size() != 8) begin miscompares++; $display("FAIL b2b_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_row[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL b2b_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_random();
    bit to;
    int rows;
    logic en;
    logic [MW-1:0] m;
    for (int p = 0; p < 4; p++) begin
      rows = $urandom_range(1, 12);
      en   = 1'($urandom_range(0, 1));
      m    = MW'($urandom);
      valid_mode = 1; ready_mode = 2;
      for (int i = 0; i < rows; i++) src_q.push_back(mk_row(DW'($urandom)));
      start_pass(rows, en, m);
      wait_done(600, to);
      $display("random pass %0d: rows=%0d en=%b mask=%b out=%0d done=%0d", p, rows, en, m, got_q.size(), done_cnt);
      vectors++; if (to) begin miscompares++; $display("FAIL rand%0d_timeout got=no_done exp=done", p); end
      vectors++; if (got_q.size() != rows) begin miscompares++; $display("FAIL rand%0d_count got=%0d exp=%0d", p, got_q.size(), rows); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_row[%0d] got=%h exp=%h", p, i, got_q[i], exp_q[i]); end
      end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL rand%0d_done got=%0d exp=1", p, done_cnt); end
      vectors++; if (max_occ > FIFO_DEPTH) begin miscompares++; $display("FAIL rand%0d_overflow got=%0d exp<=%0d", p, max_occ, FIFO_DEPTH); end
      src_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_zero_rows();
    test_mask();
    test_reset_mid_pass();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
